// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder.
// One full-adder slice, built from two half adders and an OR, is reused once per cycle.
// Operands are processed LSB first, and a carry flop links successive bits.
// A start/busy/done handshake wraps the slice, and the result is held in output registers.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             carry_q,   carry_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q,     res_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic x_c, y_c, s1_c, c1_c, s_c, c2_c, carry_nxt_c;

  // One-bit full adder made of two half adders plus an OR on the carries
  always_comb begin
    x_c         = shift_a_q[0];
    y_c         = shift_b_q[0];
    s1_c        = x_c ^ y_c;
    c1_c        = x_c & y_c;
    s_c         = s1_c ^ carry_q;
    c2_c        = s1_c & carry_q;
    carry_nxt_c = c1_c | c2_c;
  end

  // Next-state logic: sequencing, operand capture, bit shifting and result latch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = 1'b0;
          cnt_d     = '0;
          res_d     = '0;
        end
      end
      ST_RUN: begin
        carry_d   = carry_nxt_c;
        // New bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0
        res_d     = (res_q >> 1) | (WIDTH'(s_c) << (WIDTH - 1));
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Counter is held at its last value so it never wraps within an operation
          state_d = ST_DONE;
          sum_d   = res_d;
          cout_d  = carry_nxt_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
